// File: rtl/sub2_serializer.sv
// sub2_serializer: buffers sub1 result bundles in a DEPTH-entry FIFO and replays each as 7 my_t beats.
// Optional bundle counter enabled with the SUB2_STATS_EN macro.

package my_pkg;
  typedef logic [7:0] my_t;
endpackage

package lib_pkg;
  typedef logic [7:0] our_t;
endpackage

module sub2_serializer #(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  my_pkg::my_t        in_e,
  input  lib_pkg::our_t      in_f,
  input  my_pkg::my_t [0:2]  in_g,
  input  my_pkg::my_t        in_h [3],
  output logic               out_valid,
  input  logic               out_ready,
  output my_pkg::my_t        out_data,
  output lib_pkg::our_t      out_f,
  output logic [2:0]         out_idx,
  output logic               out_last
`ifdef SUB2_STATS_EN
  ,
  output logic [15:0]        bundle_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    my_pkg::my_t        e;
    lib_pkg::our_t      f;
    my_pkg::my_t [0:2]  g;
    my_pkg::my_t [0:2]  h;
  } bundle_t;

  typedef enum logic {IDLE, SEND} state_t;

  bundle_t            mem [DEPTH];
  bundle_t            in_bundle;
  bundle_t            head;
  my_pkg::my_t        elem;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [2:0]         bc;
  state_t             state;
  logic               push;
  logic               pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == SEND) && out_ready && (bc == 3'd6);

  always_comb begin
    in_bundle.e = in_e;
    in_bundle.f = in_f;
    in_bundle.g = in_g;
    for (int i = 0; i < 3; i++) in_bundle.h[i] = in_h[i];
  end

  // NOTE: the storage array carries no reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_bundle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      bc     <= 3'd0;
      state  <= IDLE;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);

      case (state)
        IDLE: begin
          if (count != '0) state <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (bc == 3'd6) begin
              bc <= 3'd0;
              // Stay in SEND when a push refills the slot being popped: no bubble.
              if (count == CNT_W'(1) && !push) state <= IDLE;
            end else begin
              bc <= bc + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode only registered state, so they hold while stalled and clear at once on reset.
  always_comb begin
    head = mem[rd_ptr];
    case (bc)
      3'd0:    elem = head.e;
      3'd1:    elem = head.g[0];
      3'd2:    elem = head.g[1];
      3'd3:    elem = head.g[2];
      3'd4:    elem = head.h[0];
      3'd5:    elem = head.h[1];
      3'd6:    elem = head.h[2];
      default: elem = '0;
    endcase
  end

  assign out_valid = (state == SEND);
  assign out_data  = out_valid ? elem : '0;
  assign out_f     = out_valid ? head.f : '0;
  assign out_idx   = bc;
  assign out_last  = out_valid && (bc == 3'd6);

`ifdef SUB2_STATS_EN
  logic [15:0] bundle_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bundle_cnt_q <= 16'd0;
    else if (pop && bundle_cnt_q != 16'hFFFF) bundle_cnt_q <= bundle_cnt_q + 16'd1;
  end

  assign bundle_cnt = bundle_cnt_q;
`endif

endmodule

// File: tb/tb_sub2_serializer.sv
// Self-checking bench for sub2_serializer: queue-based beat model plus directed literal checks.
module tb_sub2_serializer;

  localparam int DEPTH = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  my_pkg::my_t        in_e;
  lib_pkg::our_t      in_f;
  my_pkg::my_t [0:2]  in_g;
  my_pkg::my_t        in_h [3];
  logic               out_valid;
  logic               out_ready;
  my_pkg::my_t        out_data;
  lib_pkg::our_t      out_f;
  logic [2:0]         out_idx;
  logic               out_last;
`ifdef SUB2_STATS_EN
  logic [15:0]        bundle_cnt;
`endif

  sub2_serializer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_e      (in_e),
    .in_f      (in_f),
    .in_g      (in_g),
    .in_h      (in_h),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_f     (out_f),
    .out_idx   (out_idx),
    .out_last  (out_last)
`ifdef SUB2_STATS_EN
    ,
    .bundle_cnt(bundle_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected beat stream and bundle occupancy, advanced on each rising edge.
  typedef struct {
    logic [7:0] data;
    logic [7:0] f;
    int         idx;
  } beat_t;

  beat_t beats[$];
  int    occ = 0;
  int    occ_prev = 0;
  int    exp_bcnt = 0;
  int    m_next;
  bit    m_acc;
  bit    m_psh;
  beat_t m_beat;

  // A beat is on offer once a bundle has been held for at least one full edge.
  function automatic bit exp_valid();
    return (occ > 0) && (occ_prev > 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      beats.delete();
      occ = 0;
      occ_prev = 0;
      exp_bcnt = 0;
    end else begin
      m_acc  = exp_valid() && out_ready;
      m_psh  = in_valid && (occ < DEPTH);
      m_next = occ;
      if (m_acc && beats.size() > 0) begin
        m_beat = beats.pop_front();
        if (m_beat.idx == 6) begin
          m_next--;
          if (exp_bcnt < 65535) exp_bcnt++;
        end
      end
      if (m_psh) begin
        for (int i = 0; i < 7; i++) begin
          m_beat.f   = in_f;
          m_beat.idx = i;
          if (i == 0)     m_beat.data = in_e;
          else if (i < 4) m_beat.data = in_g[i-1];
          else            m_beat.data = in_h[i-4];
          beats.push_back(m_beat);
        end
        m_next++;
      end
      occ_prev = occ;
      occ = m_next;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", in_ready, (occ < DEPTH));
      check("out_valid", out_valid, exp_valid());
      if (exp_valid() && beats.size() > 0) begin
        check("out_data", out_data, beats[0].data);
        check("out_f", out_f, beats[0].f);
        check("out_idx", out_idx, beats[0].idx);
        check("out_last", out_last, (beats[0].idx == 6));
      end
`ifdef SUB2_STATS_EN
      check("bundle_cnt", bundle_cnt, exp_bcnt);
`endif
    end
  end

  task automatic push_bundle(input logic [7:0] e, input logic [7:0] f,
                             input logic [7:0] g0, input logic [7:0] g1, input logic [7:0] g2,
                             input logic [7:0] h0, input logic [7:0] h1, input logic [7:0] h2);
    in_e = e; in_f = f;
    in_g[0] = g0; in_g[1] = g1; in_g[2] = g2;
    in_h[0] = h0; in_h[1] = h1; in_h[2] = h2;
    in_valid = 1'b1;
    @(negedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_beat(input int target);
    bit found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid && out_idx == target[2:0]) begin
        found = 1;
        break;
      end
    end
    check("wait_beat_found", found, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_e = '0; in_f = '0; in_g = '0;
    for (int i = 0; i < 3; i++) in_h[i] = '0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Single bundle, consumer always ready.
    out_ready = 1'b1;
    push_bundle(8'd1, 8'd9, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);
    check("latency_idle", out_valid, 0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("single_valid", out_valid, 1);
      check("single_data", out_data, k + 1);
      check("single_idx", out_idx, k);
      check("single_f", out_f, 9);
      check("single_last", out_last, (k == 6));
    end
    @(negedge clk);
    check("single_done", out_valid, 0);

    // Backpressure at beat 2.
    #1 push_bundle(8'd1, 8'd9, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);
    wait_beat(2);
    check("bp_at2", out_data, 3);
    #1 out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_data", out_data, 3);
      check("bp_hold_idx", out_idx, 2);
    end
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_resume", out_data, 4);
    repeat (6) @(negedge clk);

    // Full FIFO: two bundles fill it, the third waits for the first to drain.
    #1 out_ready = 1'b0;
    push_bundle(8'h10, 8'hA1, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16);
    push_bundle(8'h20, 8'hA2, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26);
    check("full_ready_low", in_ready, 0);
    in_e = 8'h30; in_f = 8'hA3;
    in_g[0] = 8'h31; in_g[1] = 8'h32; in_g[2] = 8'h33;
    in_h[0] = 8'h34; in_h[1] = 8'h35; in_h[2] = 8'h36;
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("full_hold_ready", in_ready, 0);
      check("full_hold_data", out_data, 8'h10);
    end
    #1 out_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_last) begin found = 1; break; end
    end
    check("full_first_last", found, 1);
    check("full_last_data", out_data, 8'h16);
    @(negedge clk);
    check("full_refill_ready", in_ready, 1);
    check("full_next_bundle", out_data, 8'h20);
    @(negedge clk);
    #1 in_valid = 1'b0;
    check("full_again", in_ready, 0);
    repeat (20) @(negedge clk);

    // Asynchronous reset mid-stream.
    #1 push_bundle(8'h40, 8'h4F, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46);
    wait_beat(4);
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_f", out_f, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    push_bundle(8'h50, 8'h5A, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56);
    check("post_rst_idle", out_valid, 0);
    @(negedge clk);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_idx", out_idx, 0);
    check("post_rst_data", out_data, 8'h50);
    check("post_rst_f", out_f, 8'h5A);
    repeat (8) @(negedge clk);

    // Randomized traffic with varying push and accept densities.
    for (int seg = 0; seg < 6; seg++) begin
      int pv = 30 + 12 * seg;
      int pr = 95 - 13 * seg;
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        #1;
        in_valid  = ($urandom_range(0, 99) < pv);
        out_ready = ($urandom_range(0, 99) < pr);
        in_e = 8'($urandom); in_f = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
          in_g[i] = 8'($urandom);
          in_h[i] = 8'($urandom);
        end
      end
    end
    #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (30) @(negedge clk);
    check("drain_empty", beats.size(), 0);

`ifdef SUB2_STATS_EN
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    for (int b = 0; b < 5; b++) begin
      push_bundle(8'(b), 8'h77, 8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6);
      repeat (8) @(negedge clk);
      #1;
    end
    check("stats_five", bundle_cnt, 16'd5);
    dut.bundle_cnt_q = 16'hFFFE;
    exp_bcnt = 65534;
    for (int b = 0; b < 3; b++) begin
      push_bundle(8'(b), 8'h78, 8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6);
      repeat (8) @(negedge clk);
      #1;
    end
    check("stats_saturate", bundle_cnt, 16'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
